// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern_tx serial framer.
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        PAR  = 2'd3
    } state_t;

    localparam logic [3:0]  PREAMBLE = 4'b1001;
    localparam int unsigned PRE_LEN  = 4;

endpackage

// File: rtl/pattern_tx_shreg.sv
// Loadable MSB-first shift register; so always presents the current MSB.
module pattern_tx_shreg
    import pattern_tx_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         so
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign so = sr[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial framer: preamble 1001, payload MSB first, optional even parity.
// Define PATTERN_TX_PARITY_EN to append the parity bit (PAR state).
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] word,
    input  logic              valid,
    output logic              ready,
    output logic              data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hs_c;
    logic             shift_c;
    logic             so;
    logic [1:0]       pre_idx_c;

    assign hs_c = valid & ready;

    // Advance the shifter whenever the bit just placed on data came from its MSB.
    assign shift_c = ((state == PRE) && (cnt == PRE_LAST)) ||
                     ((state == PAY) && (cnt != PAY_LAST));

    // Preamble bit index for the next cycle (cnt is the bit currently on data).
    assign pre_idx_c = 2'(PRE_LEN - 2) - 2'(cnt);

    pattern_tx_shreg #(
        .W (DATA_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (hs_c),
        .shift (shift_c),
        .d     (word),
        .so    (so)
    );

`ifdef PATTERN_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (hs_c) begin
            par <= ^word;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs_c) begin
                        state <= PRE;
                        cnt   <= '0;
                        data  <= PREAMBLE[PRE_LEN-1];
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= PAY;
                        cnt   <= '0;
                        data  <= so;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        data  <= PREAMBLE[pre_idx_c];
                    end
                end
                PAY: begin
                    if (cnt == PAY_LAST) begin
`ifdef PATTERN_TX_PARITY_EN
                        state <= PAR;
                        cnt   <= '0;
                        data  <= par;
`else
                        state <= IDLE;
                        cnt   <= '0;
                        data  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ready <= 1'b1;
`endif
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        data  <= so;
                    end
                end
                default: begin
                    // PAR (or an unreachable encoding) closes the frame
                    state <= IDLE;
                    cnt   <= '0;
                    data  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
